// File: rtl/cpu_pkg.sv
// Shared pipeline types for the hazard/forwarding controller: stage records,
// hazard FSM states and forwarding select encodings.
package cpu_pkg;

  localparam int XZR = 31;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic       rw;
    logic       ld;
    logic [4:0] rd;
  } stage_rec_t;

  typedef enum logic {
    RUN,
    STALL
  } hz_state_t;

  // A stage can supply a source only if it writes a real register that is actually read
  function automatic logic rec_match(input stage_rec_t rec,
                                     input logic [4:0] src,
                                     input logic       use_src,
                                     input logic [4:0] zero_reg);
    return rec.rw && (rec.rd == src) && (src != zero_reg) && use_src;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// REG-stage decode fields in, forwarding/stall/flush controls out.
interface hazard_fwd_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       rn_r;
  logic [4:0]       ab_r;
  logic             use_rn;
  logic             use_ab;
  logic [4:0]       rd_r;
  logic             regwrite_r;
  logic             memtoreg_r;
  logic             br_taken;

  logic [1:0]       fwdr1;
  logic [1:0]       fwdr2;
  logic             pc_en;
  logic             ifreg_en;
  logic             bubble;
  logic             flush_if;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rn_r, ab_r, use_rn, use_ab, rd_r, regwrite_r, memtoreg_r, br_taken,
    input  fwdr1, fwdr2, pc_en, ifreg_en, bubble, flush_if, stall_cnt
  );

  modport slave (
    input  rn_r, ab_r, use_rn, use_ab, rd_r, regwrite_r, memtoreg_r, br_taken,
    output fwdr1, fwdr2, pc_en, ifreg_en, bubble, flush_if, stall_cnt
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Priority forwarding select for one REG-stage source operand (EX > MEM > WB > regfile).
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int ZERO_REG = XZR
) (
  input  logic [4:0] src,
  input  logic       use_src,
  input  stage_rec_t ex_rec,
  input  stage_rec_t mem_rec,
  input  stage_rec_t wb_rec,
  output logic [1:0] sel,
  output logic       ex_hit
);

  logic mem_hit;
  logic wb_hit;
  logic unused_ld;

  assign unused_ld = ex_rec.ld ^ mem_rec.ld ^ wb_rec.ld;

  always_comb begin
    ex_hit  = rec_match(ex_rec,  src, use_src, 5'(ZERO_REG));
    mem_hit = rec_match(mem_rec, src, use_src, 5'(ZERO_REG));
    wb_hit  = rec_match(wb_rec,  src, use_src, 5'(ZERO_REG));
    sel     = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use
// stall with bubble injection, branch flush and a saturating stall counter.
module hazard_fwd_ctrl
  import cpu_pkg::*;
#(
  parameter int ZERO_REG = XZR,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_fwd_ctrl_if.slave  bus
);

  stage_rec_t       ex_q;
  stage_rec_t       mem_q;
  stage_rec_t       wb_q;
  stage_rec_t       ex_next;
  hz_state_t        state_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [1:0]       sel1;
  logic [1:0]       sel2;
  logic             ex_hit1;
  logic             ex_hit2;
  logic             hz;

  fwd_sel #(
    .ZERO_REG (ZERO_REG)
  ) u_fwd_rn (
    .src     (bus.rn_r),
    .use_src (bus.use_rn),
    .ex_rec  (ex_q),
    .mem_rec (mem_q),
    .wb_rec  (wb_q),
    .sel     (sel1),
    .ex_hit  (ex_hit1)
  );

  fwd_sel #(
    .ZERO_REG (ZERO_REG)
  ) u_fwd_ab (
    .src     (bus.ab_r),
    .use_src (bus.use_ab),
    .ex_rec  (ex_q),
    .mem_rec (mem_q),
    .wb_rec  (wb_q),
    .sel     (sel2),
    .ex_hit  (ex_hit2)
  );

  // The STALL cycle always has a bubble in EX, so it can never re-trigger on the same consumer
  assign hz = ex_q.ld && (ex_hit1 || ex_hit2) && (state_q == RUN);

  // Controls must act in the same cycle the consumer sits in REG, so they are decoded
  // combinationally from the registered state rather than registered themselves.
  assign bus.fwdr1     = hz ? FWD_RF : sel1;
  assign bus.fwdr2     = hz ? FWD_RF : sel2;
  assign bus.pc_en     = ~hz;
  assign bus.ifreg_en  = ~hz;
  assign bus.bubble    = hz;
  assign bus.flush_if  = bus.br_taken & ~hz;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    ex_next = '{rw: bus.regwrite_r, ld: bus.memtoreg_r, rd: bus.rd_r};
    if (hz) begin
      ex_next = '{rw: 1'b0, ld: 1'b0, rd: bus.rd_r};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_next;
      case (state_q)
        RUN: begin
          if (hz) begin
            state_q <= STALL;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
              stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
          end
        end
        STALL: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: a cycle-by-cycle instruction table plus
// hand sequences for counter saturation and reset during a stall.
module tb_hazard_fwd_ctrl;

  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  hazard_fwd_ctrl_if #(.CNT_W(CNT_W)) bus();

  hazard_fwd_ctrl #(
    .ZERO_REG (31),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       rn;
    logic [4:0]       ab;
    logic             urn;
    logic             uab;
    logic [4:0]       rd;
    logic             rw;
    logic             ld;
    logic             br;
    logic [1:0]       f1;
    logic [1:0]       f2;
    logic             stl;
    logic             fl;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl [36];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t v(input logic [4:0] rn, input logic [4:0] ab,
                             input logic urn, input logic uab,
                             input logic [4:0] rd, input logic rw, input logic ld,
                             input logic br, input logic [1:0] f1, input logic [1:0] f2,
                             input logic stl, input logic fl, input logic [CNT_W-1:0] cnt);
    vec_t r;
    r.rn = rn; r.ab = ab; r.urn = urn; r.uab = uab;
    r.rd = rd; r.rw = rw; r.ld = ld; r.br = br;
    r.f1 = f1; r.f2 = f2; r.stl = stl; r.fl = fl; r.cnt = cnt;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    bus.rn_r       = t.rn;
    bus.ab_r       = t.ab;
    bus.use_rn     = t.urn;
    bus.use_ab     = t.uab;
    bus.rd_r       = t.rd;
    bus.regwrite_r = t.rw;
    bus.memtoreg_r = t.ld;
    bus.br_taken   = t.br;
  endtask

  task automatic apply_stimulus(input vec_t t);
    @(negedge clk);
    drive(t);
  endtask

  task automatic check_output(input string name, input vec_t t);
    logic [11:0] act;
    logic [11:0] exp;
    #1;
    act = {bus.fwdr1, bus.fwdr2, bus.pc_en, bus.ifreg_en, bus.bubble, bus.flush_if, bus.stall_cnt};
    exp = {t.f1, t.f2, ~t.stl, ~t.stl, t.stl, t.fl, t.cnt};
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got fwdr1=%0d fwdr2=%0d pc_en=%b ifreg_en=%b bubble=%b flush_if=%b stall_cnt=%0d, want fwdr1=%0d fwdr2=%0d pc_en=%b ifreg_en=%b bubble=%b flush_if=%b stall_cnt=%0d",
               name, act[11:10], act[9:8], act[7], act[6], act[5], act[4], act[3:0],
               exp[11:10], exp[9:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  initial begin
    vec_t       nop;
    vec_t       t;
    logic [CNT_W-1:0] exp_cnt;

    //        rn  ab urn uab rd rw ld br  f1 f2 stl fl cnt
    nop     = v(0,  0, 0, 0, 31, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[0]  = nop;
    tbl[1]  = v(2,  0, 1, 0,  1, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[2]  = v(1,  3, 1, 1,  2, 1, 0, 0,  1, 0, 0, 0, 0);
    tbl[3]  = v(5,  6, 1, 1,  1, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[4]  = nop;
    tbl[5]  = v(5,  1, 1, 1,  4, 1, 0, 0,  0, 2, 0, 0, 0);
    tbl[6]  = v(10, 11, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[7]  = nop;
    tbl[8]  = nop;
    tbl[9]  = v(5,  1, 1, 1,  4, 1, 0, 0,  0, 3, 0, 0, 0);
    tbl[10] = v(10, 11, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[11] = nop;
    tbl[12] = nop;
    tbl[13] = nop;
    tbl[14] = v(5,  1, 1, 1,  4, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[15] = v(2,  0, 1, 0,  7, 1, 1, 0,  0, 0, 0, 0, 0);
    tbl[16] = v(7,  7, 1, 1,  8, 1, 0, 0,  0, 0, 1, 0, 0);
    tbl[17] = v(7,  7, 1, 1,  8, 1, 0, 0,  2, 2, 0, 0, 1);
    tbl[18] = v(3,  0, 1, 0,  7, 1, 1, 0,  0, 0, 0, 0, 1);
    tbl[19] = v(0,  7, 0, 1, 31, 0, 0, 1,  0, 0, 1, 0, 1);
    tbl[20] = v(0,  7, 0, 1, 31, 0, 0, 1,  0, 2, 0, 1, 2);
    tbl[21] = v(1,  2, 1, 1, 31, 1, 0, 0,  0, 0, 0, 0, 2);
    tbl[22] = v(31, 31, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0, 2);
    tbl[23] = v(4,  0, 1, 0, 31, 1, 1, 0,  0, 0, 0, 0, 2);
    tbl[24] = v(31, 31, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 2);
    tbl[25] = v(8,  8, 1, 1,  6, 1, 0, 0,  0, 0, 0, 0, 2);
    tbl[26] = v(8,  8, 1, 1,  6, 1, 0, 0,  0, 0, 0, 0, 2);
    tbl[27] = v(8,  8, 1, 1,  6, 1, 0, 0,  0, 0, 0, 0, 2);
    tbl[28] = v(6,  6, 1, 1,  9, 1, 0, 0,  1, 1, 0, 0, 2);
    tbl[29] = v(6,  9, 1, 1, 10, 1, 0, 0,  2, 1, 0, 0, 2);
    tbl[30] = v(9,  9, 0, 0, 11, 1, 0, 0,  0, 0, 0, 0, 2);
    tbl[31] = v(12, 0, 1, 0,  7, 1, 1, 0,  0, 0, 0, 0, 2);
    tbl[32] = v(7,  0, 1, 0,  8, 1, 1, 0,  0, 0, 1, 0, 2);
    tbl[33] = v(7,  0, 1, 0,  8, 1, 1, 0,  2, 0, 0, 0, 3);
    tbl[34] = v(8,  8, 1, 1,  9, 1, 0, 0,  0, 0, 1, 0, 3);
    tbl[35] = v(8,  8, 1, 1,  9, 1, 0, 0,  2, 2, 0, 0, 4);

    drive(nop);
    repeat (2) @(negedge clk);
    check_output("reset_state", nop);
    reset = 1'b1;

    for (int i = 0; i < 36; i++) begin
      apply_stimulus(tbl[i]);
      check_output($sformatf("vec%0d", i), tbl[i]);
    end

    // Repeated load-use pairs drive the narrow counter into saturation
    exp_cnt = 4;
    for (int i = 0; i < 14; i++) begin
      t = v(12, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, exp_cnt);
      apply_stimulus(t);
      check_output($sformatf("sat%0d_load", i), t);
      t = v(7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 1, 0, exp_cnt);
      apply_stimulus(t);
      check_output($sformatf("sat%0d_hz", i), t);
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 1'b1;
      t = v(7, 7, 1, 1, 8, 1, 0, 0, 2, 2, 0, 0, exp_cnt);
      apply_stimulus(t);
      check_output($sformatf("sat%0d_fwd", i), t);
    end
    t = v(0, 0, 0, 0, 31, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    apply_stimulus(t);
    check_output("sat_hold", t);

    // Reset pulled low while the controller sits in STALL
    t = v(12, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 4'hF);
    apply_stimulus(t);
    check_output("rst_load", t);
    t = v(7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 1, 0, 4'hF);
    apply_stimulus(t);
    check_output("rst_hz", t);
    @(negedge clk);
    reset = 1'b0;
    check_output("rst_mid_stall", v(7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_output("rst_held", v(7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    t = v(7, 7, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(t);
    check_output("rst_consumer", t);
    t = v(8, 7, 1, 1, 10, 1, 0, 0, 2, 0, 0, 0, 0);
    apply_stimulus(t);
    check_output("rst_after_fwd", t);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
